// File: rtl/load_store_unit.sv
// load_store_unit: bridges one datapath load/store request at a time onto a
// word-wide request/grant/response bus. Sub-word accesses are mapped onto
// byte enables and lane-shifted data; load data is re-aligned and extended.
// Optional feature macro: LSU_MISALIGNED_EN. When defined, misaligned accesses
// are split into two consecutive word transactions; when undefined they
// complete immediately with resp_err=1 and never touch the bus.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_width,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    ISSUE2 = 3'd3,
    WAIT2  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Request fields kept for the whole access
  logic            r_we;
  logic [1:0]      r_off;
  logic [1:0]      r_width;
  logic            r_signed;
  logic            r_err;
  logic            r_split;

  // Registered bus drive plus the prepared second half of a split access
  logic            r_bus_we;
  logic [XLEN-1:0] r_bus_addr;
  logic [3:0]      r_bus_be;
  logic [XLEN-1:0] r_bus_wdata;
  logic [3:0]      r_be_hi;
  logic [XLEN-1:0] r_wdata_hi;
  logic [XLEN-1:0] r_lo_word;
  logic [XLEN-1:0] r_resp_rdata;

  // Incoming-request decode
  logic [5:0]      w_req_sh;
  logic [3:0]      w_base_be;
  logic [7:0]      w_be_full;
  logic            w_misaligned;
  logic [XLEN-1:0] w_wdata_lo;
  logic [XLEN-1:0] w_wdata_hi;

  // Load data re-alignment
  logic [5:0]      w_rd_sh;
  logic [XLEN-1:0] w_hi_word;
  logic [XLEN-1:0] w_lo_word;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_data;

  assign w_req_sh   = {1'b0, req_addr[1:0], 3'b000};
  assign w_be_full  = {4'b0000, w_base_be} << req_addr[1:0];
  assign w_wdata_lo = req_wdata << w_req_sh;
  assign w_wdata_hi = req_wdata >> (6'd32 - w_req_sh);

  assign w_rd_sh   = {1'b0, r_off, 3'b000};
  assign w_hi_word = (r_state == WAIT2) ? bus_rdata : '0;
  assign w_lo_word = (r_state == WAIT2) ? r_lo_word : bus_rdata;
  assign w_shifted = (w_lo_word >> w_rd_sh) | (w_hi_word << (6'd32 - w_rd_sh));

  assign req_ready  = (r_state == IDLE);
  assign bus_req    = (r_state == ISSUE) || (r_state == ISSUE2);
  assign resp_valid = (r_state == RESP);
  assign resp_err   = (r_state == RESP) && r_err;
  assign resp_rdata = r_resp_rdata;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_be     = r_bus_be;
  assign bus_wdata  = r_bus_wdata;

  // Byte-enable pattern and alignment check for the request being offered
  always_comb begin
    w_base_be    = 4'b1111;
    w_misaligned = 1'b0;
    case (req_width)
      WIDTH_BYTE: w_base_be = 4'b0001;
      WIDTH_HALF: begin
        w_base_be    = 4'b0011;
        w_misaligned = (req_addr[1:0] == 2'd3);
      end
      default: begin
        w_base_be    = 4'b1111;
        w_misaligned = (req_addr[1:0] != 2'd0);
      end
    endcase
  end

  // Mask the re-aligned word to the access width and extend it
  always_comb begin
    w_load_data = w_shifted;
    case (r_width)
      WIDTH_BYTE: w_load_data = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      WIDTH_HALF: w_load_data = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default:    w_load_data = w_shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; bus_rvalid only matters while waiting on the bus
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGNED_EN
          w_next_state = ISSUE;
`else
          w_next_state = w_misaligned ? RESP : ISSUE;
`endif
        end
      end
      ISSUE:  if (bus_gnt) w_next_state = WAIT;
      WAIT:   if (bus_rvalid) w_next_state = r_split ? ISSUE2 : RESP;
      ISSUE2: if (bus_gnt) w_next_state = WAIT2;
      WAIT2:  if (bus_rvalid) w_next_state = RESP;
      RESP:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the request, steer the bus between halves and capture response data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_off        <= 2'd0;
      r_width      <= 2'd0;
      r_signed     <= 1'b0;
      r_err        <= 1'b0;
      r_split      <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_be     <= 4'b0000;
      r_bus_wdata  <= '0;
      r_be_hi      <= 4'b0000;
      r_wdata_hi   <= '0;
      r_lo_word    <= '0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_off       <= req_addr[1:0];
            r_width     <= req_width;
            r_signed    <= req_signed;
            r_bus_we    <= req_we;
            r_bus_addr  <= {req_addr[XLEN-1:2], 2'b00};
            r_bus_be    <= w_be_full[3:0];
            r_bus_wdata <= w_wdata_lo;
            r_be_hi     <= w_be_full[7:4];
            r_wdata_hi  <= w_wdata_hi;
`ifdef LSU_MISALIGNED_EN
            r_split     <= w_misaligned;
            r_err       <= 1'b0;
`else
            r_split     <= 1'b0;
            r_err       <= w_misaligned;
            if (w_misaligned) begin
              r_resp_rdata <= '0;
            end
`endif
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            if (r_split) begin
              r_lo_word   <= bus_rdata;
              r_bus_addr  <= r_bus_addr + 32'd4;
              r_bus_be    <= r_be_hi;
              r_bus_wdata <= r_wdata_hi;
            end else begin
              r_resp_rdata <= r_we ? '0 : w_load_data;
            end
          end
        end
        WAIT2: begin
          if (bus_rvalid) begin
            r_resp_rdata <= r_we ? '0 : w_load_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width; only 32 is supported.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  reset.
REQ-003 SHALL have datapath-side ports: req_valid in 1 access request (mem_valid); req_ready out 1 request accepted; req_we in 1 store when 1; req_addr in 32 byte address; req_width in 2 memory_access_width_t (BYTE/HALF/WORD); req_signed in 1 sign-extend load; req_wdata in 32 store data, LSB-aligned.
REQ-004 SHALL have response ports: resp_valid out 1 one-cycle completion pulse; resp_rdata out 32 extended load data; resp_err out 1 access fault, qualified by resp_valid.
REQ-005 SHALL have bus ports: bus_req out 1; bus_we out 1; bus_addr out 32 word-aligned; bus_be out 4 byte enables; bus_wdata out 32; bus_gnt in 1; bus_rvalid in 1 completion for reads and writes; bus_rdata in 32.

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP.
REQ-007 SHALL drive req_ready=1 only in IDLE; the request is accepted on req_valid&&req_ready and latched in full.
REQ-008 SHALL transition IDLE->ISSUE on accept; ISSUE holds bus_req=1 and all bus_* stable until bus_gnt; on gnt go to WAIT.
REQ-009 SHALL sample bus_rvalid only in WAIT/WAIT2; bus_rvalid in any other state is ignored.
REQ-010 SHALL go WAIT->RESP on bus_rvalid for an aligned access; RESP drives resp_valid=1 for exactly one cycle, then returns to IDLE.
REQ-011 SHALL give aligned-access latency: accept at cycle N, bus_req at N+1; with gnt at N+1 and rvalid at N+2, resp_valid is at N+3.
REQ-012 SHALL treat an access as misaligned when HALF has addr[1:0]==3, or WORD has addr[1:0]!=0; BYTE is never misaligned.
REQ-013 SHALL set bus_addr={addr[31:2],2'b00}; bus_be = 0001/0011/1111 shifted left by addr[1:0] and truncated to 4 bits; bus_wdata=req_wdata<<(8*addr[1:0]).
REQ-014 SHALL use bus_be for both reads and writes, and drive bus_we=req_we.
REQ-015 SHALL form load data by shifting {hi_word,lo_word} right by 8*addr[1:0], where hi_word is 0 for single accesses. It masks the result to the access width and sign-extends when req_signed=1, else zero-extends; WORD ignores req_signed.
REQ-016 SHALL drive resp_rdata=0 for stores and for errored accesses.
REQ-017 SHALL hold resp_rdata stable from the RESP cycle until the next RESP cycle.

Reset
REQ-018 SHALL, with rst=1 at a clock edge, enter IDLE and clear req_ready to 1 and bus_req, resp_valid, resp_err, resp_rdata, bus_be, bus_we, bus_addr and bus_wdata to 0.
REQ-019 SHALL abandon any in-flight access on reset mid-operation, with no resp_valid; a late bus_rvalid arriving in IDLE is ignored.

Configuration
REQ-020 SHALL honour macro LSU_MISALIGNED_EN.
REQ-021 SHALL, when LSU_MISALIGNED_EN is defined, split a misaligned access into two word transactions:
- first at {addr[31:2],00} with the upper enables;
- ISSUE2/WAIT2 at first address +4 (wraps 0xFFFFFFFC->0x00000000), bus_be = the remaining low bytes, bus_wdata = req_wdata>>(8*(4-addr[1:0]));
- RESP follows WAIT2; resp_err=0.
REQ-022 SHALL, when LSU_MISALIGNED_EN is undefined, handle a misaligned access as IDLE->RESP with resp_err=1, issuing no bus_req; latency is accept N -> resp_valid N+1.

Verification
REQ-023 SHALL cover a signed byte load: addr 0x102, bus_rdata 0x00800000 -> bus_be 0100, resp_rdata 0xFFFFFF80.
REQ-024 SHALL cover a half store: addr 0x06, wdata 0x0000BEEF -> bus_addr 0x04, bus_be 1100, bus_wdata 0xBEEF0000, bus_we=1.
REQ-025 SHALL cover grant stall: bus_gnt held low 5 cycles -> bus_req, bus_addr and bus_be stable throughout; resp_valid exactly 2 cycles after gnt when rvalid follows gnt by one cycle.
REQ-026 SHALL cover a misaligned word load at addr 0x0000_0001 with words 0x44332211 and 0x88776655. With LSU_MISALIGNED_EN: bus_be 1110 then 0001, resp_rdata 0x55443322. Without it: no bus_req, resp_err=1.
REQ-027 SHALL cover reset during WAIT: next cycle req_ready=1; a subsequent stray bus_rvalid produces no resp_valid.
REQ-028 SHALL cover an unsigned half load: addr 0x2, bus_rdata 0xF00D0000, req_signed=0 -> resp_rdata 0x0000F00D.
